bt_cmd_ctrl: RTL and testbench

//  Parametrised Bluetooth command controller for the MP3 player. Consumes bytes

---
 rtl/bt_cmd_ctrl_if.sv | 9 +
 rtl/bt_cmd_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bt_cmd_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bt_cmd_ctrl_if.sv
// bt_cmd_ctrl_if: byte stream from the UART receiver to the command controller
//   rx_valid  one-cycle strobe, rx_data valid
//   rx_data   received command/argument byte
interface bt_cmd_ctrl_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   modport master (output rx_valid, rx_data);
   modport slave  (input  rx_valid, rx_data);
endinterface

// File: rtl/bt_cmd_ctrl.sv
// bt_cmd_ctrl: Bluetooth command controller driving song/pause/volume/effect/repeat state
//   clk, rst       clock, synchronous active-high reset
//   i_rx           command/argument byte stream (slave)
//   i_finish_song  strobe: current song ended
//   o_song_select  current song index      o_vol_level  attenuation level
//   o_vol          {att,att}               o_pause/o_repeat  mode flags
//   o_effect       decoder effect word
//   o_next/o_pre/o_restart/o_vol_evt/o_err  one-cycle event pulses
module bt_cmd_ctrl #(
   parameter int SONG_NUM    = 4,
   parameter int SONG_W      = 3,
   parameter int VOL_LEVELS  = 9,
   parameter int VOL_STEP    = 14,
   parameter int HOLD_CYCLES = 50000000,
   parameter int ARG_TIMEOUT = 1000000
) (
   input  logic               clk,
   input  logic               rst,
   bt_cmd_ctrl_if.slave       i_rx,
   input  logic               i_finish_song,
   output logic [SONG_W-1:0]  o_song_select,
   output logic [3:0]         o_vol_level,
   output logic [15:0]        o_vol,
   output logic               o_pause,
   output logic               o_repeat,
   output logic [15:0]        o_effect,
   output logic               o_next,
   output logic               o_pre,
   output logic               o_restart,
   output logic               o_vol_evt,
   output logic               o_err
);
   localparam int CNT_MAX = HOLD_CYCLES > ARG_TIMEOUT ? HOLD_CYCLES : ARG_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  ARG_LAST  = CNT_W'(ARG_TIMEOUT - 1);
   localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(SONG_NUM - 1);
   localparam logic [3:0]        VOL_LAST  = 4'(VOL_LEVELS - 1);
   typedef enum logic [1:0] {S_IDLE, S_ARG, S_LOCK} state_t;
   state_t            r_state, w_state;
   logic [CNT_W-1:0]  r_cnt, w_cnt;
   logic              r_arg_vol, w_arg_vol;
   logic [SONG_W-1:0] r_song, w_song, w_song_fin;
   logic [3:0]        r_level, w_level;
   logic              r_pause, w_pause, r_repeat, w_repeat;
   logic [15:0]       r_effect, w_effect;
   logic              r_next, w_next, r_pre, w_pre, r_restart, w_restart;
   logic              r_vol_evt, w_vol_evt, r_err, w_err;
   logic              w_arg_ok;
   logic [7:0]        w_att;
   // song end is applied before any user byte of the same cycle
   assign w_song_fin = (i_finish_song && !r_repeat) ? ((r_song == SONG_LAST) ? '0 : r_song + 1'b1) : r_song;
   assign w_arg_ok   = r_arg_vol ? (32'(i_rx.rx_data) < VOL_LEVELS) : (32'(i_rx.rx_data) < SONG_NUM);
   assign w_att      = (r_level == VOL_LAST) ? 8'hFC : 8'(VOL_STEP * int'(r_level));
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_arg_vol = r_arg_vol;
      w_song    = w_song_fin;
      w_level   = r_level;
      w_pause   = r_pause;
      w_repeat  = r_repeat;
      w_effect  = r_effect;
      w_next    = 1'b0;
      w_pre     = 1'b0;
      w_restart = i_finish_song && r_repeat;
      w_vol_evt = 1'b0;
      w_err     = 1'b0;
      case (r_state)
         S_IDLE: if (i_rx.rx_valid) begin
            case (i_rx.rx_data)
               8'h01: w_pause = ~r_pause;
               8'h02: begin
                  w_song  = (w_song_fin == SONG_LAST) ? '0 : w_song_fin + 1'b1;
                  w_next  = 1'b1;
                  w_state = S_LOCK;
                  w_cnt   = '0;
               end
               8'h03: begin
                  w_song  = (w_song_fin == '0) ? SONG_LAST : w_song_fin - 1'b1;
                  w_pre   = 1'b1;
                  w_state = S_LOCK;
                  w_cnt   = '0;
               end
               8'h04, 8'h05: begin
                  // saturating steps still count as a volume event
                  w_level   = i_rx.rx_data[0] ? ((r_level == VOL_LAST) ? r_level : r_level + 1'b1)
                                              : ((r_level == 4'd0) ? r_level : r_level - 1'b1);
                  w_vol_evt = 1'b1;
                  w_state   = S_LOCK;
                  w_cnt     = '0;
               end
               8'h07: w_repeat = ~r_repeat;
               8'h10, 8'h11: begin
                  w_arg_vol = i_rx.rx_data[0];
                  w_state   = S_ARG;
                  w_cnt     = '0;
               end
               8'h40: w_effect = 16'h0000;
               8'h41: w_effect = 16'h7000;
               8'h42: w_effect = 16'h00F0;
               default: w_err = 1'b1;
            endcase
         end
         S_ARG: begin
            if (i_rx.rx_valid) begin
               w_state = w_arg_ok ? S_LOCK : S_IDLE;
               w_cnt   = '0;
               w_err   = !w_arg_ok;
               if (w_arg_ok && r_arg_vol) begin
                  w_level   = i_rx.rx_data[3:0];
                  w_vol_evt = 1'b1;
               end
               if (w_arg_ok && !r_arg_vol) begin
                  w_song = i_rx.rx_data[SONG_W-1:0];
                  w_next = 1'b1;
               end
            end else if (r_cnt == ARG_LAST) begin
               w_state = S_IDLE;
               w_err   = 1'b1;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         S_LOCK: begin
            // bytes during lockout are discarded but flagged
            w_err   = i_rx.rx_valid;
            w_state = (r_cnt == HOLD_LAST) ? S_IDLE : S_LOCK;
            w_cnt   = (r_cnt == HOLD_LAST) ? '0 : r_cnt + 1'b1;
         end
         default: w_state = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_arg_vol <= 1'b0;
         r_song    <= '0;
         r_level   <= 4'd0;
         r_pause   <= 1'b1;
         r_repeat  <= 1'b0;
         r_effect  <= 16'h0000;
         r_next    <= 1'b0;
         r_pre     <= 1'b0;
         r_restart <= 1'b0;
         r_vol_evt <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_arg_vol <= w_arg_vol;
         r_song    <= w_song;
         r_level   <= w_level;
         r_pause   <= w_pause;
         r_repeat  <= w_repeat;
         r_effect  <= w_effect;
         r_next    <= w_next;
         r_pre     <= w_pre;
         r_restart <= w_restart;
         r_vol_evt <= w_vol_evt;
         r_err     <= w_err;
      end
   end
   assign o_song_select = r_song;
   assign o_vol_level   = r_level;
   assign o_vol         = {w_att, w_att};
   assign o_pause       = r_pause;
   assign o_repeat      = r_repeat;
   assign o_effect      = r_effect;
   assign o_next        = r_next;
   assign o_pre         = r_pre;
   assign o_restart     = r_restart;
   assign o_vol_evt     = r_vol_evt;
   assign o_err         = r_err;
endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// tb_bt_cmd_ctrl: randomized and directed bench for bt_cmd_ctrl against a behavioural model
module tb_bt_cmd_ctrl;
   localparam int SN = 4, SW = 3, VL = 9, VS = 14, HOLD = 6, TMO = 10;
   logic clk = 1'b0, rst = 1'b1, fin = 1'b0;
   logic [SW-1:0] song;
   logic [3:0]  level;
   logic [15:0] vol, effect;
   logic pause, rep, nxt, pre, restart, vol_evt, err;
   int checks = 0, errors = 0;
   bt_cmd_ctrl_if rx_bus();
   bt_cmd_ctrl #(.SONG_NUM(SN), .SONG_W(SW), .VOL_LEVELS(VL), .VOL_STEP(VS),
                 .HOLD_CYCLES(HOLD), .ARG_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .i_rx(rx_bus), .i_finish_song(fin),
      .o_song_select(song), .o_vol_level(level), .o_vol(vol), .o_pause(pause),
      .o_repeat(rep), .o_effect(effect), .o_next(nxt), .o_pre(pre),
      .o_restart(restart), .o_vol_evt(vol_evt), .o_err(err));
   always #5 clk = ~clk;
   int m_song, m_level, m_lock, m_age;
   bit m_pause, m_rep, m_arg, m_argvol, m_valid;
   bit m_next, m_pre, m_rst_p, m_ve, m_err;
   logic [15:0] m_eff;
   function automatic logic [7:0] att(int l);
      return (l == VL - 1) ? 8'hFC : 8'(l * VS);
   endfunction
   task automatic model_step();
      bit v = rx_bus.rx_valid;
      int d = int'(rx_bus.rx_data);
      {m_next, m_pre, m_rst_p, m_ve, m_err} = '0;
      if (rst) begin
         m_song = 0; m_level = 0; m_pause = 1; m_rep = 0; m_eff = 16'h0000;
         m_lock = 0; m_arg = 0; m_age = 0; m_valid = 1;
         return;
      end
      if (fin) begin
         if (m_rep) m_rst_p = 1;
         else m_song = (m_song + 1) % SN;
      end
      if (m_lock > 0) begin
         m_err = v;
         m_lock--;
      end else if (m_arg) begin
         if (v) begin
            m_arg = 0;
            if (m_argvol && d < VL) begin m_level = d; m_ve = 1; m_lock = HOLD; end
            else if (!m_argvol && d < SN) begin m_song = d; m_next = 1; m_lock = HOLD; end
            else m_err = 1;
         end else begin
            m_age++;
            if (m_age == TMO) begin m_err = 1; m_arg = 0; end
         end
      end else if (v) begin
         case (d)
            'h01: m_pause = !m_pause;
            'h02: begin m_song = (m_song + 1) % SN; m_next = 1; m_lock = HOLD; end
            'h03: begin m_song = (m_song + SN - 1) % SN; m_pre = 1; m_lock = HOLD; end
            'h04: begin m_level = (m_level > 0) ? m_level - 1 : 0; m_ve = 1; m_lock = HOLD; end
            'h05: begin m_level = (m_level < VL - 1) ? m_level + 1 : VL - 1; m_ve = 1; m_lock = HOLD; end
            'h07: m_rep = !m_rep;
            'h10, 'h11: begin m_arg = 1; m_age = 0; m_argvol = (d == 'h11); end
            'h40: m_eff = 16'h0000;
            'h41: m_eff = 16'h7000;
            'h42: m_eff = 16'h00F0;
            default: m_err = 1;
         endcase
      end
   endtask
   initial forever begin
      logic [45:0] act, exp;
      @(negedge clk);
      if (m_valid) begin
         act = {song, level, vol, pause, rep, effect, nxt, pre, restart, vol_evt, err};
         exp = {SW'(m_song), 4'(m_level), att(m_level), att(m_level), m_pause, m_rep, m_eff,
                m_next, m_pre, m_rst_p, m_ve, m_err};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got=%h expected=%h", $time, act, exp);
         end
      end
      model_step();
   end
   task automatic lit(input string n, input logic [15:0] a, input logic [15:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask
   task automatic tick(input logic v, input logic [7:0] d, input logic f);
      rx_bus.rx_valid = v;
      rx_bus.rx_data  = d;
      fin = f;
      @(posedge clk);
      #1;
      rx_bus.rx_valid = 1'b0;
      rx_bus.rx_data  = 8'h00;
      fin = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00, 1'b0);
   endtask
   logic [7:0] pool [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07,
                             8'h10, 8'h11, 8'h40, 8'h41, 8'h42, 8'h00};
   initial begin
      rx_bus.rx_valid = 1'b0;
      rx_bus.rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      lit("reset_song", 16'(song), 16'h0);
      lit("reset_level", 16'(level), 16'h0);
      lit("reset_vol", vol, 16'h0000);
      lit("reset_pause", 16'(pause), 16'h1);
      lit("reset_effect", effect, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 8'h02, 1'b0);
         lit("next_pulse", 16'(nxt), 16'h1);
         lit("next_song", 16'(song), 16'((i + 1) % 4));
         idle(HOLD);
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 8'h05, 1'b0);
         lit("voldn_evt", 16'(vol_evt), 16'h1);
         idle(HOLD);
      end
      lit("vol_sat_level", 16'(level), 16'h8);
      lit("vol_sat_word", vol, 16'hFCFC);
      tick(1'b1, 8'h11, 1'b0);
      tick(1'b1, 8'h03, 1'b0);
      lit("setvol_level", 16'(level), 16'h3);
      lit("setvol_word", vol, 16'h2A2A);
      idle(HOLD);
      tick(1'b1, 8'h10, 1'b0);
      tick(1'b1, 8'h07, 1'b0);
      lit("badarg_err", 16'(err), 16'h1);
      lit("badarg_song", 16'(song), 16'h0);
      tick(1'b1, 8'h10, 1'b0);
      idle(TMO - 1);
      lit("pre_timeout_err", 16'(err), 16'h0);
      idle(1);
      lit("timeout_err", 16'(err), 16'h1);
      tick(1'b1, 8'h10, 1'b0);
      tick(1'b1, 8'h02, 1'b0);
      lit("select_song", 16'(song), 16'h2);
      idle(HOLD);
      tick(1'b1, 8'h07, 1'b0);
      tick(1'b0, 8'h00, 1'b1);
      lit("repeat_restart", 16'(restart), 16'h1);
      lit("repeat_song", 16'(song), 16'h2);
      tick(1'b1, 8'h07, 1'b0);
      tick(1'b0, 8'h00, 1'b1);
      lit("finish_advance", 16'(song), 16'h3);
      tick(1'b1, 8'h02, 1'b0);
      lit("wrap_song", 16'(song), 16'h0);
      tick(1'b1, 8'h01, 1'b0);
      lit("drop_err", 16'(err), 16'h1);
      lit("drop_pause", 16'(pause), 16'h1);
      idle(HOLD);
      tick(1'b1, 8'h10, 1'b0);
      tick(1'b1, 8'h02, 1'b0);
      idle(HOLD);
      tick(1'b1, 8'h03, 1'b1);
      lit("finish_prev_song", 16'(song), 16'h2);
      idle(HOLD);
      tick(1'b1, 8'h02, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      rst = 1'b1;
      tick(1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      lit("rst_lock_song", 16'(song), 16'h0);
      tick(1'b1, 8'h01, 1'b0);
      lit("post_rst_pause", 16'(pause), 16'h0);
      repeat (4000) begin
         logic [7:0] d;
         rst = ($urandom_range(0, 199) == 0);
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : pool[$urandom_range(0, 11)];
         tick($urandom_range(0, 2) == 0, d, $urandom_range(0, 19) == 0);
      end
      rst = 1'b0;
      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
